// File: rtl/des_dec_key_schedule.sv
// DES key schedule for decryption: emits K16 down to K1 over a valid/ready handshake.
// The PC-1 halves are right-rotated after each transfer, undoing the encryption-order left shifts.
module des_dec_key_schedule (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] key_in,
    input  logic        key_load,
    output logic        busy,
    output logic [47:0] subkey_out,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round_idx,
    output logic        done
);

    typedef enum logic {IDLE, EMIT} state_t;

    // FIPS 46-3 tables, 1-based bit numbers with bit 1 as the MSB.
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_t      state, state_next;
    logic [27:0] c_reg, d_reg, c_next, d_next;
    logic [3:0]  round, round_next;
    logic        done_next;
    logic        single_shift;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[55-i] = k[64-PC1_TAB[i]];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[47-i] = cd[56-PC2_TAB[i]];
        end
        return r;
    endfunction

    // Round 16 is held as 4'd0, so decrementing from it lands naturally on 15.
    assign single_shift = (round == 4'd0) || (round == 4'd1) ||
                          (round == 4'd2) || (round == 4'd9);

    always_comb begin
        state_next   = state;
        c_next       = c_reg;
        d_next       = d_reg;
        round_next   = round;
        done_next    = 1'b0;
        busy         = 1'b0;
        subkey_valid = 1'b0;
        case (state)
            IDLE: begin
                if (key_load) begin
                    {c_next, d_next} = pc1(key_in);
                    round_next       = 4'd0;
                    state_next       = EMIT;
                end
            end
            EMIT: begin
                busy         = 1'b1;
                subkey_valid = 1'b1;
                if (subkey_ready) begin
                    if (round == 4'd1) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        if (single_shift) begin
                            c_next = {c_reg[0], c_reg[27:1]};
                            d_next = {d_reg[0], d_reg[27:1]};
                        end else begin
                            c_next = {c_reg[1:0], c_reg[27:2]};
                            d_next = {d_reg[1:0], d_reg[27:2]};
                        end
                        round_next = round - 4'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            c_reg <= '0;
            d_reg <= '0;
            round <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            c_reg <= c_next;
            d_reg <= d_next;
            round <= round_next;
            done  <= done_next;
        end
    end

    assign subkey_out = pc2({c_reg, d_reg});
    assign round_idx  = round;

endmodule
